// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared widths, FSM states and requester indices for the port-0 arbiter
package sram_arb_pkg;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_WMASKS = 4;
    localparam int REQ0 = 0;
    localparam int REQ1 = 1;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/sram_rr_arbiter2.sv
// sram_rr_arbiter2: two-way round-robin grant with a registered last-served index
module sram_rr_arbiter2 import sram_arb_pkg::*; (
    input  logic       clk0,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       rr_last
);
    // lone requester wins outright; a tie goes to whoever was not served last
    always_comb begin
        grant = !advance ? 2'b00 : (&valid) ? (rr_last ? 2'b01 : 2'b10) : valid;
    end
    // remember the served requester so the next tie flips
    always_ff @(posedge clk0) begin
        if (rst)
            rr_last <= 1'b1;
        else if (|grant)
            rr_last <= grant[REQ1];
    end
endmodule

// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: scrubs the SRAM after reset, then shares port 0 between two requesters
module sram_port0_arbiter import sram_arb_pkg::*; #(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_WMASKS    = DEF_NUM_WMASKS,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_we,
    input  logic [2*NUM_WMASKS-1:0]   req_wmask,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      init_done,
    output logic                      sram_csb0,
    output logic                      sram_web0,
    output logic [NUM_WMASKS-1:0]     sram_wmask0,
    output logic [ADDR_WIDTH-1:0]     sram_addr0,
    output logic [DATA_WIDTH-1:0]     sram_din0,
    input  logic [DATA_WIDTH-1:0]     sram_dout0
);
    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic                    done_q;
    logic                    rd_pend;
    logic                    rr_last;
    logic [1:0]              grant;
    logic                    any_grant;
    logic                    init_wr;
    logic                    sel;
    logic                    we_g;
    logic [NUM_WMASKS-1:0]   wmask_g;
    logic [ADDR_WIDTH-1:0]   addr_g;
    logic [DATA_WIDTH-1:0]   wdata_g;

    sram_rr_arbiter2 u_arb (
        .clk0    (wb_clk_i),
        .rst     (wb_rst_i),
        .valid   (req_valid),
        .advance (done_q & ~wb_rst_i),
        .grant   (grant),
        .rr_last (rr_last)
    );

    // select the granted requester's fields and drive the macro pins; scrub writes take priority
    always_comb begin
        any_grant   = |grant;
        sel         = grant[REQ1];
        init_wr     = (state == ST_INIT) & ~wb_rst_i;
        we_g        = sel ? req_we[REQ1] : req_we[REQ0];
        wmask_g     = sel ? req_wmask[2*NUM_WMASKS-1:NUM_WMASKS] : req_wmask[NUM_WMASKS-1:0];
        addr_g      = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        wdata_g     = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        req_ready   = grant;
        sram_csb0   = ~(init_wr | any_grant);
        sram_web0   = any_grant ? ~we_g : 1'b0;
        sram_wmask0 = init_wr ? '1 : (any_grant & we_g) ? wmask_g : '0;
        sram_addr0  = init_wr ? init_cnt : any_grant ? addr_g : '0;
        sram_din0   = any_grant ? wdata_g : '0;
        rsp_valid   = (rd_pend & ~wb_rst_i) ? (rr_last ? 2'b10 : 2'b01) : 2'b00;
        rsp_rdata   = sram_dout0;
        init_done   = done_q & ~wb_rst_i;
    end

    // scrub FSM: walk every word once, then stay in RUN until reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            init_cnt <= '0;
            done_q   <= 1'b0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == {ADDR_WIDTH{1'b1}}) begin
                state  <= ST_RUN;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b1;
        end
    end

    // a granted read answers next cycle; rr_last then names the requester it belongs to
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            rd_pend <= 1'b0;
        else
            rd_pend <= any_grant & ~we_g;
    end
endmodule

// File: tb/tb_sram_port0_arbiter.sv
// tb_sram_port0_arbiter: directed stimulus with a response scoreboard against a behavioural SRAM
module tb_sram_port0_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int NW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [1:0]      req_we = '0;
    logic [2*NW-1:0] req_wmask = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            init_done;
    logic            sram_csb0;
    logic            sram_web0;
    logic [NW-1:0]   sram_wmask0;
    logic [AW-1:0]   sram_addr0;
    logic [DW-1:0]   sram_din0;
    logic [DW-1:0]   sram_dout0;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    logic [DW-1:0] mem [512];
    logic          l_csb = 1'b1;
    logic          l_web = 1'b1;
    logic [NW-1:0] l_m;
    logic [AW-1:0] l_a;
    logic [DW-1:0] l_d;

    always #5 clk = ~clk;

    sram_port0_arbiter dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_wmask   (req_wmask),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .init_done   (init_done),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    // macro model: pins captured on the rising edge, array accessed on the falling edge
    always @(posedge clk) begin
        l_csb <= sram_csb0;
        l_web <= sram_web0;
        l_m   <= sram_wmask0;
        l_a   <= sram_addr0;
        l_d   <= sram_din0;
    end
    always @(negedge clk) begin
        if (!l_csb) begin
            if (!l_web) begin
                for (int b = 0; b < NW; b++)
                    if (l_m[b]) mem[l_a][b*8 +: 8] <= l_d[b*8 +: 8];
            end else begin
                sram_dout0 <= mem[l_a];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every response must match the oldest expectation for that requester
    always @(negedge clk) begin
        #1;
        if (rsp_valid[0]) begin
            if (q0.size() == 0) chk("rsp0 unexpected", 64'(rsp_valid[0]), 64'd0);
            else chk("rsp0 data", 64'(rsp_rdata), 64'(q0.pop_front()));
        end
        if (rsp_valid[1]) begin
            if (q1.size() == 0) chk("rsp1 unexpected", 64'(rsp_valid[1]), 64'd0);
            else chk("rsp1 data", 64'(rsp_rdata), 64'(q1.pop_front()));
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset();
        #1;
        chk("reset csb", 64'(sram_csb0), 64'd1);
        chk("reset ready", 64'(req_ready), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset init_done", 64'(init_done), 64'd0);
        chk("reset pins", 64'({sram_web0, sram_wmask0, sram_addr0, sram_din0}), 64'd0);
    endtask

    task automatic scrub(input int stop);
        rst       = 1'b0;
        req_valid = 2'b11;
        req_we    = 2'b00;
        for (int k = 0; k < 512; k++) begin
            if (k == stop) begin
                rst       = 1'b1;
                req_valid = 2'b00;
                #1;
                chk("abort csb", 64'(sram_csb0), 64'd1);
                next_cyc();
                return;
            end
            #1;
            chk("scrub pins", 64'({sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, req_ready, init_done}),
                64'({1'b0, 1'b0, 4'hf, AW'(k), 32'h0, 2'b00, 1'b0}));
            next_cyc();
        end
        req_valid = 2'b00;
        #1;
        chk("init_done rise", 64'(init_done), 64'd1);
        next_cyc();
    endtask

    task automatic issue(input int i, input logic we, input logic [NW-1:0] m, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] e);
        logic got;
        got                    = 1'b0;
        req_valid              = 2'b00;
        req_valid[i]           = 1'b1;
        req_we[i]              = we;
        req_wmask[i*NW +: NW]  = m;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
        for (int t = 0; t < 20 && !got; t++) begin
            #1;
            if (req_ready[i]) begin
                got = 1'b1;
                if (!we) begin
                    if (i == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
            end
            next_cyc();
        end
        if (!got) chk("issue timeout", 64'(req_ready[i]), 64'd1);
    endtask

    task automatic idle();
        req_valid = 2'b00;
        next_cyc();
    endtask

    initial begin
        req_valid = 2'b11;
        next_cyc();
        next_cyc();
        check_reset();
        next_cyc();
        scrub(512);
        issue(0, 1'b1, 4'hf, 9'd5, 32'hDEADBEEF, 32'h0);
        issue(0, 1'b0, 4'h0, 9'd5, 32'h0, 32'hDEADBEEF);
        issue(1, 1'b1, 4'h5, 9'd7, 32'hAABBCCDD, 32'h0);
        issue(1, 1'b0, 4'h0, 9'd7, 32'h0, 32'h00BB00DD);
        issue(0, 1'b1, 4'hf, 9'd9, 32'h12345678, 32'h0);
        issue(0, 1'b0, 4'h0, 9'd9, 32'h0, 32'h12345678);
        issue(0, 1'b1, 4'h0, 9'd5, 32'hFFFFFFFF, 32'h0);
        issue(0, 1'b0, 4'h0, 9'd5, 32'h0, 32'hDEADBEEF);
        issue(0, 1'b1, 4'hf, 9'd1, 32'h11111111, 32'h0);
        issue(1, 1'b1, 4'hf, 9'd2, 32'h22222222, 32'h0);
        idle();
        req_we    = 2'b00;
        req_addr  = {9'd2, 9'd1};
        req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("contention ready", 64'(req_ready), (c % 2) ? 64'd2 : 64'd1);
            if (c % 2) q1.push_back(32'h22222222);
            else q0.push_back(32'h11111111);
            next_cyc();
        end
        req_valid = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("lone r1 ready", 64'(req_ready), 64'd2);
            q1.push_back(32'h22222222);
            next_cyc();
        end
        idle();
        idle();
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {9'd0, 9'd5};
        #1;
        chk("pre-reset ready", 64'(req_ready), 64'd1);
        next_cyc();
        rst       = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("dropped rsp_valid", 64'(rsp_valid), 64'd0);
        check_reset();
        next_cyc();
        scrub(200);
        scrub(512);
        issue(0, 1'b0, 4'h0, 9'd5, 32'h0, 32'h0);
        issue(1, 1'b0, 4'h0, 9'd7, 32'h0, 32'h0);
        idle();
        idle();
        idle();
        chk("q0 drained", 64'(q0.size()), 64'd0);
        chk("q1 drained", 64'(q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
